// File: rtl/bananachine_pkg.sv
// Shared definitions for the PSR / branch-resolution slice: PSR bit positions,
// condition-code encodings and the branch unit FSM state encoding.
package bananachine_pkg;

  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  localparam logic [15:0] PSR_IMPL_MASK = 16'h00E5;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bu_state_t;

endpackage

// File: rtl/psr_branch_unit_cond_eval.sv
// Combinational condition evaluator: PSR flags + 4-bit condition code -> taken.
// Shared with the decoder hazard logic, so it carries no state.
module cond_eval
  import bananachine_pkg::*;
(
  input  logic [15:0] psr,
  input  logic [3:0]  cond,
  output logic        taken
);

  logic c, l, f, z, n;

  assign c = psr[PSR_C];
  assign l = psr[PSR_L];
  assign f = psr[PSR_F];
  assign z = psr[PSR_Z];
  assign n = psr[PSR_N];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_HI: taken = l;
      COND_LS: taken = !l;
      COND_GT: taken = n;
      COND_LE: taken = !n;
      COND_FS: taken = f;
      COND_FC: taken = !f;
      COND_LO: taken = !l && !z;
      COND_HS: taken = l || z;
      COND_LT: taken = !n && !z;
      COND_GE: taken = n || z;
      COND_UC: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/psr_branch_unit.sv
// PSR register plus Bcond/Jcond resolver with a one-deep valid/ready response slot.
// Optional build macro PSR_BYPASS_EN forwards same-cycle flag writes into evaluation.
module psr_branch_unit
  import bananachine_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int DISP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       alu_flags,
  input  logic              we_cf,
  input  logic              we_nzl,
  input  logic              psr_we,
  input  logic [15:0]       psr_wdata,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_jump,
  input  logic [3:0]        req_cond,
  input  logic [PC_W-1:0]   req_pc,
  input  logic [DISP_W-1:0] req_disp,
  input  logic [PC_W-1:0]   req_target,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_taken,
  output logic [PC_W-1:0]   rsp_next_pc,
  output logic [15:0]       psr,
  output bu_state_t         dbg_state
);

  // Handshake: a transfer happens on any rising edge where valid && ready are both
  // high; valid never drops and payload never changes until that edge.

  logic [15:0]     alu_impl;
  logic [15:0]     psr_nxt;
  logic [15:0]     eval_psr;
  logic            cond_taken;
  logic [PC_W-1:0] disp_sext;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] next_pc;
  logic            accept;
  bu_state_t       state;

  assign alu_impl = alu_flags & PSR_IMPL_MASK;

  // LPR overrides ALU writes; the two ALU write groups touch disjoint bits.
  always_comb begin
    psr_nxt = psr;
    if (psr_we) begin
      psr_nxt = psr_wdata & PSR_IMPL_MASK;
    end else begin
      if (we_cf) begin
        psr_nxt[PSR_C] = alu_impl[PSR_C];
        psr_nxt[PSR_F] = alu_impl[PSR_F];
      end
      if (we_nzl) begin
        psr_nxt[PSR_N] = alu_impl[PSR_N];
        psr_nxt[PSR_Z] = alu_impl[PSR_Z];
        psr_nxt[PSR_L] = alu_impl[PSR_L];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psr <= '0;
    end else begin
      psr <= psr_nxt;
    end
  end

`ifdef PSR_BYPASS_EN
  assign eval_psr = psr_nxt;
`else
  assign eval_psr = psr;
`endif

  cond_eval u_cond_eval (
    .psr   (eval_psr),
    .cond  (req_cond),
    .taken (cond_taken)
  );

  assign disp_sext     = {{(PC_W-DISP_W){req_disp[DISP_W-1]}}, req_disp};
  assign branch_target = req_jump ? req_target : (req_pc + disp_sext);
  assign next_pc       = cond_taken ? branch_target : (req_pc + PC_W'(1));

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      rsp_valid   <= 1'b0;
      rsp_taken   <= 1'b0;
      rsp_next_pc <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_RESP;
            rsp_valid   <= 1'b1;
            rsp_taken   <= cond_taken;
            rsp_next_pc <= next_pc;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            if (req_valid) begin
              rsp_taken   <= cond_taken;
              rsp_next_pc <= next_pc;
            end else begin
              state     <= ST_IDLE;
              rsp_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
